// File: rtl/wisc_pkg.sv
// Shared WISC-15 definitions: opcodes, ALU commands, the control bundle and halt states.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_NAND   = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_SLL    = 4'h5;
  localparam logic [3:0] OP_SRL    = 4'h6;
  localparam logic [3:0] OP_SRA    = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_CALL   = 4'hD;
  localparam logic [3:0] OP_RET    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_PADDSB = 4'b0010;
  localparam logic [3:0] ALU_NAND   = 4'b1000;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SLL    = 4'b1100;
  localparam logic [3:0] ALU_SRL    = 4'b1110;
  localparam logic [3:0] ALU_SRA    = 4'b1111;

  typedef struct packed {
    logic [3:0] alu_cmd;
    logic       alu_src;
    logic       reg_wrt;
    logic       mem_to_reg;
    logic       mem_wrt;
    logic       branch;
    logic       call;
    logic       ret;
    logic       halt;
    logic       set_over;
    logic       set_zero;
    logic       llb;
    logic       lhb;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_st_t;

endpackage

// File: rtl/wisc_ctrl_decode.sv
// Purely combinational opcode-to-control decode; shared with the single-cycle core.
module wisc_ctrl_decode
  import wisc_pkg::*;
(
  input  logic [3:0]        op_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (op_i)
      OP_ADD:    begin c.alu_cmd = ALU_ADD;    c.reg_wrt = 1'b1; c.set_over = 1'b1; c.set_zero = 1'b1; end
      OP_PADDSB: begin c.alu_cmd = ALU_PADDSB; c.reg_wrt = 1'b1; end
      OP_SUB:    begin c.alu_cmd = ALU_SUB;    c.reg_wrt = 1'b1; c.set_over = 1'b1; c.set_zero = 1'b1; end
      OP_NAND:   begin c.alu_cmd = ALU_NAND;   c.reg_wrt = 1'b1; c.set_zero = 1'b1; end
      OP_XOR:    begin c.alu_cmd = ALU_XOR;    c.reg_wrt = 1'b1; c.set_zero = 1'b1; end
      OP_SLL:    begin c.alu_cmd = ALU_SLL;    c.reg_wrt = 1'b1; c.set_zero = 1'b1; c.alu_src = 1'b1; end
      OP_SRL:    begin c.alu_cmd = ALU_SRL;    c.reg_wrt = 1'b1; c.set_zero = 1'b1; c.alu_src = 1'b1; end
      OP_SRA:    begin c.alu_cmd = ALU_SRA;    c.reg_wrt = 1'b1; c.set_zero = 1'b1; c.alu_src = 1'b1; end
      OP_LW:     begin c.reg_wrt = 1'b1; c.mem_to_reg = 1'b1; c.alu_src = 1'b1; end
      OP_SW:     begin c.mem_wrt = 1'b1; c.alu_src = 1'b1; end
      OP_LHB:    begin c.reg_wrt = 1'b1; c.lhb = 1'b1; end
      OP_LLB:    begin c.reg_wrt = 1'b1; c.llb = 1'b1; end
      OP_B:      c.branch = 1'b1;
      OP_CALL:   begin c.reg_wrt = 1'b1; c.call = 1'b1; end
      OP_RET:    c.ret = 1'b1;
      OP_HLT:    c.halt = 1'b1;
      default:   c = '0;
    endcase
  end

  assign ctrl_o = c;

endmodule

// File: rtl/wisc_id_ctrl.sv
// Registered decode/control stage: ID/EX bundle, load-use bubbles, stall/flush handling
// and a halt-drain FSM that raises halted once in-flight work has retired.
module wisc_id_ctrl
  import wisc_pkg::*;
#(
  parameter int IW           = 16,
  parameter int RAW          = 4,
  parameter int DRAIN_CYCLES = 3
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  input  logic [IW-1:0]  instr,
  output logic           instr_ready,
  input  logic           stall_in,
  input  logic           flush,
  output logic           ex_valid,
  output logic [3:0]     ex_alu_cmd,
  output logic           ex_alu_src,
  output logic           ex_reg_wrt,
  output logic           ex_mem_to_reg,
  output logic           ex_mem_wrt,
  output logic           ex_branch,
  output logic           ex_call,
  output logic           ex_ret,
  output logic           ex_halt,
  output logic           ex_set_over,
  output logic           ex_set_zero,
  output logic           ex_llb,
  output logic           ex_lhb,
  output logic [RAW-1:0] ex_rd,
  output logic           hazard,
  output logic           halted
);

  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  logic [3:0]     op;
  logic [RAW-1:0] rd, rs, rt;
  assign op = instr[IW-1 -: 4];
  assign rd = instr[8 +: RAW];
  assign rs = instr[4 +: RAW];
  assign rt = instr[0 +: RAW];

  logic [CTRL_W-1:0] dec_bits;
  ctrl_t             dec_ctrl;

  wisc_ctrl_decode u_decode (
    .op_i   (op),
    .ctrl_o (dec_bits)
  );
  assign dec_ctrl = ctrl_t'(dec_bits);

  logic           ex_valid_q, ex_valid_d;
  ctrl_t          ex_ctrl_q, ex_ctrl_d;
  logic [RAW-1:0] ex_rd_q, ex_rd_d;
  halt_st_t       state_q;
  logic [3:0]     cnt_q;
  logic           halted_q;
  logic           accept;

  // Source-register usage: rs for ops 0-9, rt for ops 0-4, rd is read by SW and LHB.
  logic use_rs, use_rt, use_rd;
  assign use_rs = (op <= OP_SW);
  assign use_rt = (op <= OP_XOR);
  assign use_rd = (op == OP_SW) || (op == OP_LHB);

  assign hazard = ex_valid_q && ex_ctrl_q.mem_to_reg && instr_valid &&
                  ((use_rs && ex_rd_q == rs) || (use_rt && ex_rd_q == rt) ||
                   (use_rd && ex_rd_q == rd));

  assign instr_ready = !rst && (state_q == ST_RUN) && !flush && !stall_in && !hazard;
  assign accept      = instr_valid && instr_ready;

  // Anything that is neither a held stall nor an accept becomes a bubble.
  always_comb begin
    ex_valid_d = 1'b0;
    ex_ctrl_d  = '0;
    ex_rd_d    = '0;
    if (!flush && stall_in) begin
      ex_valid_d = ex_valid_q;
      ex_ctrl_d  = ex_ctrl_q;
      ex_rd_d    = ex_rd_q;
    end else if (accept) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = dec_ctrl;
      ex_rd_d    = rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_rd_q    <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rd_q    <= ex_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept && dec_ctrl.halt) begin
            state_q <= ST_DRAIN;
            cnt_q   <= CNT_INIT;
          end
        end
        ST_DRAIN: begin
          // A flush means the hlt was on the wrong path.
          if (flush) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end else if (!stall_in) begin
            if (cnt_q == 4'd0) begin
              state_q  <= ST_HALTED;
              halted_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
        end
        ST_HALTED: halted_q <= 1'b1;
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_alu_cmd    = ex_ctrl_q.alu_cmd;
  assign ex_alu_src    = ex_ctrl_q.alu_src;
  assign ex_reg_wrt    = ex_ctrl_q.reg_wrt;
  assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
  assign ex_mem_wrt    = ex_ctrl_q.mem_wrt;
  assign ex_branch     = ex_ctrl_q.branch;
  assign ex_call       = ex_ctrl_q.call;
  assign ex_ret        = ex_ctrl_q.ret;
  assign ex_halt       = ex_ctrl_q.halt;
  assign ex_set_over   = ex_ctrl_q.set_over;
  assign ex_set_zero   = ex_ctrl_q.set_zero;
  assign ex_llb        = ex_ctrl_q.llb;
  assign ex_lhb        = ex_ctrl_q.lhb;
  assign ex_rd         = ex_rd_q;
  assign halted        = halted_q;

endmodule

// File: doc/wisc_id_ctrl.md
# wisc_id_ctrl

Registered instruction-decode/control stage for the pipelined WISC-15 core. It sits between the fetch stage and the ID/EX pipeline register. It decodes each accepted 16-bit instruction into a complete control bundle and registers it for EX. It also handles load-use stall insertion, downstream back-pressure, branch flush and a halt-drain state machine that asserts `halted` only after in-flight work has retired.

## Interface
Parameters:
- `IW`, 16, instruction width; opcode in `[IW-1:IW-4]`, rd `[11:8]`, rs `[7:4]`, rt `[3:0]`.
- `RAW`, 4, register-address width.
- `DRAIN_CYCLES`, 3, number of non-stalled cycles after hlt capture before `halted` rises; legal range 1..15.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `instr_valid`  in  1  fetch presents `instr`.
- `instr`  in  IW  instruction word.
- `instr_ready`  out  1  combinational; instruction is consumed when `instr_valid && instr_ready`.
- `stall_in`  in  1  EX cannot accept; hold ID/EX.
- `flush`  in  1  branch/call/ret redirect from EX.
- `ex_valid`  out  1  bundle is a real instruction.
- `ex_alu_cmd`  out  4  ALU command.
- `ex_alu_src`, `ex_reg_wrt`, `ex_mem_to_reg`, `ex_mem_wrt`, `ex_branch`, `ex_call`, `ex_ret`, `ex_halt`, `ex_set_over`, `ex_set_zero`, `ex_llb`, `ex_lhb`  out  1 each  control bits.
- `ex_rd`  out  RAW  destination register.
- `hazard`  out  1  combinational load-use detect.
- `halted`  out  1  core halted; sticky.

## Operation
- Decode is a full function with no don't-cares and no latches. Fields not listed below are 0:
  - ADD 0: cmd 0000, reg_wrt, set_over, set_zero.
  - PADDSB 1: cmd 0010, reg_wrt.
  - SUB 2: cmd 0001, reg_wrt, set_over, set_zero.
  - NAND 3: cmd 1000, reg_wrt, set_zero.
  - XOR 4: cmd 0100, reg_wrt, set_zero.
  - SLL 5: cmd 1100; SRL 6: cmd 1110; SRA 7: cmd 1111. Each also asserts reg_wrt, set_zero and alu_src.
  - LW 8: reg_wrt, mem_to_reg, alu_src.
  - SW 9: mem_wrt, alu_src.
  - LHB A: reg_wrt, lhb. LLB B: reg_wrt, llb.
  - B C: branch. CALL D: reg_wrt, call. RET E: ret. HLT F: halt.
- Hazard detection:
  - `hazard = ex_valid && ex_mem_to_reg && instr_valid && (ex_rd == rs || ex_rd == rt || ((op==SW || op==LHB) && ex_rd == rd))`.
  - rs/rt compares apply only for opcodes 0-9. rt applies only for opcodes 0-4.
- `instr_ready = !rst && state==RUN && !flush && !stall_in && !hazard`.
- Per-cycle priority: rst > flush > stall_in > hazard > accept > idle.
  - flush: load a bubble.
  - stall_in: hold every `ex_*` register.
  - hazard: load a bubble.
  - accept: load the decoded bundle, `ex_valid`=1.
  - idle: load a bubble.
- Bubble: `ex_valid` and every `ex_*` output are 0.
- Halt FSM has three states:
  - RUN to DRAIN when a HLT is accepted; the counter loads DRAIN_CYCLES-1.
  - DRAIN: the counter decrements on each cycle with `!stall_in`. At counter 0 with `!stall_in`, go to HALTED.
  - DRAIN with flush: return to RUN, clear the counter and load a bubble. The hlt was wrong-path.
  - HALTED: `halted`=1, `instr_ready`=0, bubbles only. Only `rst` exits.

## Timing
- Decode latency is 1 cycle: an instruction accepted at edge N appears on `ex_*` after edge N.
- Reset values: `ex_*` all 0, `ex_valid`=0, state RUN, counter 0, `halted`=0.
- `instr_ready` is 0 during reset.
- Reset mid-DRAIN or in HALTED returns to RUN on the next edge.
- A load-use hazard costs exactly one bubble. On the next cycle the hazard clears because `ex_valid` is 0.
- flush and hazard in the same cycle: flush wins and the instruction is not consumed.
- stall_in and flush in the same cycle: flush wins and the ID/EX register is overwritten with a bubble.
- `halted` rises DRAIN_CYCLES non-stalled cycles after the hlt is captured in ID/EX. With no stalls and DRAIN_CYCLES=3, a hlt accepted at edge N gives `halted`=1 after edge N+3.
- No combinational path from `instr` to `ex_*`. `hazard` and `instr_ready` are combinational from `instr`, `instr_valid`, `flush`, `stall_in` and internal state.

## Structure
- Shared package `wisc_pkg` holds:
  - opcode localparams OP_ADD..OP_HLT;
  - ALU command localparams ALU_ADD, ALU_SUB, ALU_PADDSB, ALU_NAND, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA;
  - the packed control-bundle typedef `ctrl_t`;
  - halt state encodings ST_RUN, ST_DRAIN, ST_HALTED.
- One sub-module, `wisc_ctrl_decode`: purely combinational, opcode to `ctrl_t`. It is reusable by the single-cycle core.

## Test plan
- Reset held for 2 cycles with `instr_valid`=1 -> all outputs 0, `instr_ready`=0. Then 16 back-to-back opcodes 0x0-0xF -> each bundle matches the decode list one cycle later.
- `LW R3,0(R1)` followed by `ADD R4,R3,R2` -> `hazard`=1 for one cycle, one bubble, ADD appears 2 cycles after LW. Follow-up `ADD R4,R5,R2` -> no bubble.
- `stall_in`=1 for 3 cycles while ID/EX holds SUB -> `ex_*` unchanged, `instr_ready`=0. On release, the next instruction is loaded.
- HLT accepted, DRAIN_CYCLES=3, `stall_in`=1 for one cycle during drain -> `halted` rises 4 cycles after capture and stays high. `rst` -> RUN.
- HLT accepted, `flush`=1 on the next cycle -> state RUN, `ex_valid`=0, `halted` never rises, next instruction accepted.
- `flush`=1 and `stall_in`=1 together with XOR in ID/EX -> ID/EX becomes a bubble and the instruction on `instr` is not consumed.
